// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: S-box, RCON, FSM encodings and word helpers.
package aes_pkg;

  localparam int AES128_NROUNDS = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2,
    ZERO   = 2'd3
  } state_t;

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Round 10 has no successor key, so indices past 9 return zero.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd0:    r = 8'h01;
      4'd1:    r = 8'h02;
      4'd2:    r = 8'h04;
      4'd3:    r = 8'h08;
      4'd4:    r = 8'h10;
      4'd5:    r = 8'h20;
      4'd6:    r = 8'h40;
      4'd7:    r = 8'h80;
      4'd8:    r = 8'h1b;
      4'd9:    r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = SBOX[a];

endmodule

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: writes round keys 0..10 to the round-key SRAM, one per cycle.
// Optional macro AES_KEY_EXPAND_ZEROIZE_EN adds a zeroize input that scrubs all 11 SRAM words.
//
// state  | meaning
// IDLE   | waiting for a key, key_ready high
// EXPAND | writing rk_reg to address round, advancing the schedule
// DONE   | one-cycle done pulse after round key 10
// ZERO   | writing zero to addresses 0..10 (zeroize build only)
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [0:DATA_WIDTH-1] key,
  input  logic                  key_valid,
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  output logic                  key_ready,
  output logic                  busy,
  output logic                  done,
  output logic [0:DATA_WIDTH-1] sram_i_data,
  output logic [0:ADDR_WIDTH-1] sram_addr,
  output logic                  sram_w_e
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROUND = ADDR_WIDTH'(AES128_NROUNDS);

  state_t                state;
  logic [127:0]          rk_reg;
  logic [ADDR_WIDTH-1:0] round;
  logic                  wr_en;
  logic                  zero_req;

  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
  assign zero_req = zeroize;
`else
  assign zero_req = 1'b0;
`endif

  assign {w0, w1, w2, w3} = rk_reg;
  assign rot = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sbox
    aes_sbox u_sbox (
      .a (rot[8*i +: 8]),
      .y (sub[8*i +: 8])
    );
  end

  assign n0      = w0 ^ sub ^ {rcon(round[3:0]), 24'h0};
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // The key register and round counter double as the SRAM data/address flops.
  assign sram_i_data = rk_reg;
  assign sram_addr   = round;
  assign sram_w_e    = wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      round     <= '0;
      rk_reg    <= '0;
      key_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_en     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (zero_req) begin
            state     <= ZERO;
            rk_reg    <= '0;
            round     <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            wr_en     <= 1'b1;
          end else if (key_valid) begin
            state     <= EXPAND;
            rk_reg    <= key;
            round     <= '0;
            key_ready <= 1'b0;
            busy      <= 1'b1;
            wr_en     <= 1'b1;
          end
        end
        EXPAND: begin
          if (zero_req) begin
            state  <= ZERO;
            rk_reg <= '0;
            round  <= '0;
          end else if (round == LAST_ROUND) begin
            state <= DONE;
            wr_en <= 1'b0;
            done  <= 1'b1;
          end else begin
            rk_reg <= next_rk;
            round  <= round + ADDR_WIDTH'(1);
          end
        end
        DONE: begin
          state     <= IDLE;
          key_ready <= 1'b1;
          busy      <= 1'b0;
        end
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
        ZERO: begin
          if (round == LAST_ROUND) begin
            state     <= IDLE;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            key_ready <= 1'b1;
          end else begin
            round <= round + ADDR_WIDTH'(1);
          end
        end
`endif
        default: begin
          state     <= IDLE;
          wr_en     <= 1'b0;
          busy      <= 1'b0;
          key_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed self-checking bench for aes_key_expand using FIPS-197 and published key-schedule vectors.
module tb_aes_key_expand;

  logic         clk;
  logic         reset_n;
  logic [0:127] key;
  logic         key_valid;
  logic         zeroize;
  logic         key_ready;
  logic         busy;
  logic         done;
  logic [0:127] sram_i_data;
  logic [0:3]   sram_addr;
  logic         sram_w_e;

  int n_checks;
  int n_errors;
  int cyc;

  logic [127:0] wr_data [32];
  logic [3:0]   wr_addr [32];
  int           wr_cyc  [32];
  int           wr_n;
  int           done_n;
  int           done_cyc;

  typedef struct {
    logic [127:0] k;
    logic [127:0] r1;
    logic [127:0] r10;
  } vec_t;

  vec_t         vecs [3];
  logic [127:0] fips_rk [11];

  aes_key_expand #(.ADDR_WIDTH(4), .DATA_WIDTH(128)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .key         (key),
    .key_valid   (key_valid),
`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    .zeroize     (zeroize),
`endif
    .key_ready   (key_ready),
    .busy        (busy),
    .done        (done),
    .sram_i_data (sram_i_data),
    .sram_addr   (sram_addr),
    .sram_w_e    (sram_w_e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sram_w_e) begin
      if (wr_n < 32) begin
        wr_data[wr_n] = sram_i_data;
        wr_addr[wr_n] = sram_addr;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
    end
    if (done) begin
      done_n   = done_n + 1;
      done_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_n     = 0;
    done_n   = 0;
    done_cyc = -1;
  endtask

  // Presents k until accepted; returns handshake cycle with key_valid dropped one cycle later.
  task automatic apply(input logic [127:0] k, output int t);
    int guard;
    key       = k;
    key_valid = 1'b1;
    guard     = 0;
    while (!key_ready && guard < 40) begin
      step();
      guard++;
    end
    check_int("handshake_timeout", int'(key_ready), 1);
    t = cyc;
    step();
    key_valid = 1'b0;
  endtask

  task automatic wait_done();
    int start;
    int guard;
    start = done_n;
    guard = 0;
    while (done_n == start && guard < 40) begin
      step();
      guard++;
    end
    check_int("done_timeout", done_n - start, 1);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (!key_ready && guard < 40) begin
      step();
      guard++;
    end
    check_int("idle_timeout", int'(key_ready), 1);
  endtask

  initial begin
    int  t, t2, n_before;
    logic addr_ok;

    vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                128'ha0fafe1788542cb123a339392a6c7605,
                128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    vecs[1] = '{128'h00000000000000000000000000000000,
                128'h62636363626363636263636362636363,
                128'hb4ef5bcb3e92e21123e951cf6f8f188e};
    vecs[2] = '{128'h000102030405060708090a0b0c0d0e0f,
                128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
                128'h13111d7fe3944a17f307a78b4d2b30c5};

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    n_checks  = 0;
    n_errors  = 0;
    cyc       = 0;
    key       = '0;
    key_valid = 1'b0;
    zeroize   = 1'b0;
    clear_log();

    reset_n = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_key_ready", 128'(key_ready), 128'd1);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_w_e", 128'(sram_w_e), 128'd0);
    check("rst_addr", 128'(sram_addr), 128'd0);
    check("rst_data", sram_i_data, 128'd0);
    step();
    step();
    reset_n = 1'b1;
    step();

    // Back-to-back: each key is presented in the first cycle key_ready returns.
    for (int v = 0; v < 3; v++) begin
      clear_log();
      apply(vecs[v].k, t);
      wait_done();
      check_int("busy_in_done", int'(busy), 1);
      check_int("done_cycle", done_cyc - t, 12);
      check_int("write_count", wr_n, 11);
      addr_ok = 1'b1;
      for (int i = 0; i < 11; i++)
        if (wr_addr[i] != 4'(i) || wr_cyc[i] != t + 1 + i) addr_ok = 1'b0;
      check_int("addr_sequence", int'(addr_ok), 1);
      check("rk0", wr_data[0], vecs[v].k);
      check("rk1", wr_data[1], vecs[v].r1);
      check("rk10", wr_data[10], vecs[v].r10);
      if (v == 0)
        for (int i = 0; i < 11; i++) check($sformatf("fips_rk%0d", i), wr_data[i], fips_rk[i]);
      step();
      check_int("ready_after_done", int'(key_ready), 1);
      check_int("ready_cycle", cyc - t, 13);
      check_int("single_done", done_n, 1);
    end

    // key_valid held high; a different key shows up at T+3 and must wait for T+13.
    clear_log();
    key       = vecs[0].k;
    key_valid = 1'b1;
    t = cyc;
    repeat (3) step();
    key = vecs[2].k;
    wait_done();
    step();
    check_int("hold_first_writes", wr_n, 11);
    check("hold_first_rk10", wr_data[10], vecs[0].r10);
    check_int("hold_ready_cycle", cyc - t, 13);
    t2 = cyc;
    step();
    key_valid = 1'b0;
    wait_done();
    check_int("hold_total_writes", wr_n, 22);
    check("hold_second_rk0", wr_data[11], vecs[2].k);
    check("hold_second_rk10", wr_data[21], vecs[2].r10);
    check_int("hold_second_start", wr_cyc[11] - t2, 1);
    check_int("hold_second_done", done_cyc - t, 25);
    repeat (3) step();
    check_int("hold_no_queue", wr_n, 22);

    // Asynchronous reset mid-expansion.
    wait_idle();
    clear_log();
    apply(vecs[0].k, t);
    repeat (4) step();
    check_int("pre_reset_writes", wr_n, 5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_w_e", 128'(sram_w_e), 128'd0);
    check("async_key_ready", 128'(key_ready), 128'd1);
    check("async_busy", 128'(busy), 128'd0);
    n_before = wr_n;
    step();
    step();
    reset_n = 1'b1;
    step();
    check_int("no_writes_in_reset", wr_n, n_before);
    clear_log();
    apply(vecs[1].k, t);
    wait_done();
    check_int("post_reset_writes", wr_n, 11);
    check("post_reset_rk1", wr_data[1], vecs[1].r1);
    check("post_reset_rk10", wr_data[10], vecs[1].r10);

`ifdef AES_KEY_EXPAND_ZEROIZE_EN
    wait_idle();
    clear_log();
    apply(vecs[0].k, t);
    repeat (3) step();
    zeroize = 1'b1;
    step();
    zeroize = 1'b0;
    wait_idle();
    check_int("zero_ready_cycle", cyc - t, 16);
    check_int("zero_write_count", wr_n, 15);
    addr_ok = 1'b1;
    for (int i = 0; i < 11; i++)
      if (wr_addr[4 + i] != 4'(i) || wr_data[4 + i] != 128'd0) addr_ok = 1'b0;
    check_int("zero_writes_ok", int'(addr_ok), 1);
    check("zero_pre_abort_rk3", wr_data[3], fips_rk[3]);
    check_int("zero_no_done", done_n, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
